// File: rtl/regfile_sb.sv
// regfile_sb: register file with a per-register scoreboard.
//
// Holds NREG x XLEN storage and NREG pending bits. Index 0 always reads as
// zero and is never pending. An accepted issue marks its destination
// pending. A writeback stores the data and clears the pending bit. Reads are
// combinational. When BYPASS=1, a writeback in the same cycle is forwarded
// to a matching read port.
//
// Ports:
//   clk      in   sole clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   W_en     in   writeback enable
//   Rd       in   writeback register index      [AW]
//   Wr_data  in   writeback data                [XLEN]
//   Rs1/Rs2  in   read port indices             [AW]
//   Iss_en   in   issue request
//   Iss_rd   in   destination of issuing instr  [AW]
//   Rd_data1/Rd_data2 out  read data            [XLEN]
//   Busy1/Busy2       out  read index has an outstanding write
//   Stall             out  issue blocked this cycle
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG),
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            W_en,
    input  logic [AW-1:0]   Rd,
    input  logic [XLEN-1:0] Wr_data,
    input  logic [AW-1:0]   Rs1,
    input  logic [AW-1:0]   Rs2,
    input  logic            Iss_en,
    input  logic [AW-1:0]   Iss_rd,
    output logic [XLEN-1:0] Rd_data1,
    output logic [XLEN-1:0] Rd_data2,
    output logic            Busy1,
    output logic            Busy2,
    output logic            Stall
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_pend;

    // Forwarding and issue are qualified with rst_n. This keeps every output
    // at zero while reset is held, even if W_en or Iss_en is asserted then.
    logic w_wen;
    logic w_iss;
    logic w_byp1;
    logic w_byp2;
    logic w_busy1;
    logic w_busy2;
    logic w_waw;
    logic w_stall;
    logic w_iss_set;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;

    assign w_wen  = W_en & rst_n;
    assign w_iss  = Iss_en & rst_n;
    assign w_byp1 = (BYPASS != 0) && w_wen && (Rd == Rs1) && (Rs1 != {AW{1'b0}});
    assign w_byp2 = (BYPASS != 0) && w_wen && (Rd == Rs2) && (Rs2 != {AW{1'b0}});

    // r_pend[0] is held at zero, so index 0 is never busy.
    assign w_busy1 = r_pend[Rs1] & ~w_byp1;
    assign w_busy2 = r_pend[Rs2] & ~w_byp2;

    // A pending destination blocks issue, unless that same register is being
    // written back in this cycle. This applies even without bypass.
    assign w_waw     = r_pend[Iss_rd] & ~(w_wen && (Rd == Iss_rd));
    assign w_stall   = w_iss & (w_busy1 | w_busy2 | w_waw);
    assign w_iss_set = w_iss & ~w_stall & (Iss_rd != {AW{1'b0}});

    // Read port 1 mux: zero register, forwarded writeback, or stored value.
    always_comb begin
        w_rd1 = {XLEN{1'b0}};
        if (Rs1 == {AW{1'b0}}) begin
            w_rd1 = {XLEN{1'b0}};
        end else if (w_byp1) begin
            w_rd1 = Wr_data;
        end else begin
            w_rd1 = r_regs[Rs1];
        end
    end

    // Read port 2 mux: zero register, forwarded writeback, or stored value.
    always_comb begin
        w_rd2 = {XLEN{1'b0}};
        if (Rs2 == {AW{1'b0}}) begin
            w_rd2 = {XLEN{1'b0}};
        end else if (w_byp2) begin
            w_rd2 = Wr_data;
        end else begin
            w_rd2 = r_regs[Rs2];
        end
    end

    // Register storage. Writes to index 0 are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= {XLEN{1'b0}};
            end
        end else if (W_en && (Rd != {AW{1'b0}})) begin
            r_regs[Rd] <= Wr_data;
        end else begin
            r_regs[Rd] <= r_regs[Rd];
        end
    end

    // Pending bits. An accepted issue takes priority over a clearing
    // writeback to the same index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= {NREG{1'b0}};
        end else begin
            r_pend[0] <= 1'b0;
            for (int i = 1; i < NREG; i++) begin
                if (w_iss_set && (Iss_rd == AW'(i))) begin
                    r_pend[i] <= 1'b1;
                end else if (W_en && (Rd == AW'(i))) begin
                    r_pend[i] <= 1'b0;
                end else begin
                    r_pend[i] <= r_pend[i];
                end
            end
        end
    end

    assign Rd_data1 = w_rd1;
    assign Rd_data2 = w_rd2;
    assign Busy1    = w_busy1;
    assign Busy2    = w_busy2;
    assign Stall    = w_stall;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed bench for regfile_sb (XLEN=32, NREG=32, BYPASS=1).
// Inputs change 1 time unit after a rising edge.
// Outputs are checked 1 time unit after that.
module tb_regfile_sb;

    logic        clk;
    logic        rst_n;
    logic        W_en;
    logic [4:0]  Rd;
    logic [31:0] Wr_data;
    logic [4:0]  Rs1;
    logic [4:0]  Rs2;
    logic        Iss_en;
    logic [4:0]  Iss_rd;
    logic [31:0] Rd_data1;
    logic [31:0] Rd_data2;
    logic        Busy1;
    logic        Busy2;
    logic        Stall;

    int total;
    int bad;

    regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .W_en     (W_en),
        .Rd       (Rd),
        .Wr_data  (Wr_data),
        .Rs1      (Rs1),
        .Rs2      (Rs2),
        .Iss_en   (Iss_en),
        .Iss_rd   (Iss_rd),
        .Rd_data1 (Rd_data1),
        .Rd_data2 (Rd_data2),
        .Busy1    (Busy1),
        .Busy2    (Busy2),
        .Stall    (Stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        W_en = 1'b0; Rd = 5'd0; Wr_data = 32'h0;
        Iss_en = 1'b0; Iss_rd = 5'd0;
        Rs1 = 5'd0; Rs2 = 5'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle();
        // Writeback and issue while reset is held: outputs stay 0, and no
        // state change survives release.
        W_en = 1'b1; Rd = 5'd1; Wr_data = 32'hDEADBEEF;
        Iss_en = 1'b1; Iss_rd = 5'd2; Rs1 = 5'd1; Rs2 = 5'd2;
        #2;
        chk("rst_rd1", Rd_data1, 32'h0);
        chk("rst_busy2", {31'd0, Busy2}, 32'h0);
        chk("rst_stall", {31'd0, Stall}, 32'h0);
        tick();
        tick();
        chk("rst_rd1_held", Rd_data1, 32'h0);
        idle();
        rst_n = 1'b1;
        Rs1 = 5'd1; Rs2 = 5'd2;
        #1;
        chk("post_rst_rd1", Rd_data1, 32'h0);
        chk("post_rst_busy2", {31'd0, Busy2}, 32'h0);
        tick();

        // Plain write to r1, then read both ports.
        idle();
        W_en = 1'b1; Rd = 5'd1; Wr_data = 32'hA5A5A5A5;
        tick();
        idle();
        Rs1 = 5'd1; Rs2 = 5'd2;
        #1;
        chk("wr1_rd1", Rd_data1, 32'hA5A5A5A5);
        chk("wr1_rd2", Rd_data2, 32'h0);
        chk("wr1_busy1", {31'd0, Busy1}, 32'h0);

        // Writes to r0 are ignored, and r0 is never made pending.
        idle();
        W_en = 1'b1; Rd = 5'd0; Wr_data = 32'hFFFFFFFF;
        #1;
        chk("r0_nobypass", Rd_data1, 32'h0);
        tick();
        idle();
        #1;
        chk("r0_rd1", Rd_data1, 32'h0);
        Iss_en = 1'b1; Iss_rd = 5'd0;
        #1;
        chk("r0_iss_stall", {31'd0, Stall}, 32'h0);
        tick();
        idle();
        #1;
        chk("r0_busy1", {31'd0, Busy1}, 32'h0);
        Iss_en = 1'b1; Iss_rd = 5'd0;
        #1;
        chk("r0_iss_again", {31'd0, Stall}, 32'h0);
        tick();

        // Bypass: issue r3, then write r3 while reading it in the same cycle.
        idle();
        Iss_en = 1'b1; Iss_rd = 5'd3;
        tick();
        idle();
        Rs1 = 5'd3;
        #1;
        chk("r3_busy1", {31'd0, Busy1}, 32'h1);
        chk("r3_old", Rd_data1, 32'h0);
        W_en = 1'b1; Rd = 5'd3; Wr_data = 32'h12345678;
        #1;
        chk("byp_rd1", Rd_data1, 32'h12345678);
        chk("byp_busy1", {31'd0, Busy1}, 32'h0);
        tick();
        idle();
        Rs1 = 5'd3;
        #1;
        chk("r3_stored", Rd_data1, 32'h12345678);
        chk("r3_cleared", {31'd0, Busy1}, 32'h0);

        // Issue r5, which makes later reads of r5 busy; a dependent issue stalls.
        idle();
        Iss_en = 1'b1; Iss_rd = 5'd5;
        #1;
        chk("iss5_stall", {31'd0, Stall}, 32'h0);
        tick();
        idle();
        Rs2 = 5'd5;
        #1;
        chk("r5_busy2", {31'd0, Busy2}, 32'h1);
        Iss_en = 1'b1; Iss_rd = 5'd6; Rs1 = 5'd5; Rs2 = 5'd0;
        #1;
        chk("raw_stall", {31'd0, Stall}, 32'h1);
        tick();
        idle();
        Rs1 = 5'd6;
        #1;
        chk("stalled_no_pend6", {31'd0, Busy1}, 32'h0);
        W_en = 1'b1; Rd = 5'd5; Wr_data = 32'hCAFEF00D; Rs2 = 5'd5;
        #1;
        chk("wb5_byp_busy2", {31'd0, Busy2}, 32'h0);
        tick();
        idle();
        Rs2 = 5'd5;
        #1;
        chk("wb5_busy2", {31'd0, Busy2}, 32'h0);
        chk("wb5_rd2", Rd_data2, 32'hCAFEF00D);

        // Pending r7: a reissue to r7 stalls, unless r7 is written back in
        // the same cycle. In that case the issue wins and r7 stays pending.
        idle();
        Iss_en = 1'b1; Iss_rd = 5'd7;
        tick();
        idle();
        Iss_en = 1'b1; Iss_rd = 5'd7;
        #1;
        chk("waw_stall", {31'd0, Stall}, 32'h1);
        W_en = 1'b1; Rd = 5'd7; Wr_data = 32'h77777777;
        #1;
        chk("waw_wb_stall", {31'd0, Stall}, 32'h0);
        tick();
        idle();
        Rs1 = 5'd7; Rs2 = 5'd7;
        #1;
        chk("r7_rd1", Rd_data1, 32'h77777777);
        chk("r7_rd2", Rd_data2, 32'h77777777);
        chk("r7_busy1", {31'd0, Busy1}, 32'h1);
        chk("r7_busy2", {31'd0, Busy2}, 32'h1);

        // Reset asserted between clock edges clears state immediately.
        idle();
        Iss_en = 1'b1; Iss_rd = 5'd5;
        tick();
        idle();
        Rs1 = 5'd1; Rs2 = 5'd5;
        #1;
        chk("pre_rst_rd1", Rd_data1, 32'hA5A5A5A5);
        chk("pre_rst_busy2", {31'd0, Busy2}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_rd1", Rd_data1, 32'h0);
        chk("async_busy2", {31'd0, Busy2}, 32'h0);
        Rs1 = 5'd7; Iss_en = 1'b1; Iss_rd = 5'd5;
        #1;
        chk("async_busy1_r7", {31'd0, Busy1}, 32'h0);
        chk("async_stall", {31'd0, Stall}, 32'h0);
        idle();
        rst_n = 1'b1;
        Rs1 = 5'd7; Rs2 = 5'd3;
        #1;
        chk("after_rst_r7", Rd_data1, 32'h0);
        chk("after_rst_r3", Rd_data2, 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count (power of 2, >=2).
REQ-003 SHALL have parameter AW, default $clog2(NREG), register index width.
REQ-004 SHALL have parameter BYPASS, default 1, enabling same-cycle write-to-read forwarding when set to 1.
REQ-005 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port W_en  input  1  writeback enable.
REQ-008 SHALL have port Rd  input  AW  writeback register index.
REQ-009 SHALL have port Wr_data  input  XLEN  writeback data.
REQ-010 SHALL have port Rs1  input  AW  read port 1 index.
REQ-011 SHALL have port Rs2  input  AW  read port 2 index.
REQ-012 SHALL have port Iss_en  input  1  issue request: marks Iss_rd pending.
REQ-013 SHALL have port Iss_rd  input  AW  destination index of the issuing instruction.
REQ-014 SHALL have port Rd_data1  output  XLEN  read data, port 1.
REQ-015 SHALL have port Rd_data2  output  XLEN  read data, port 2.
REQ-016 SHALL have port Busy1  output  1  Rs1 has an outstanding write.
REQ-017 SHALL have port Busy2  output  1  Rs2 has an outstanding write.
REQ-018 SHALL have port Stall  output  1  issue blocked this cycle.

Function
REQ-019 SHALL hold NREG x XLEN storage plus NREG pending bits; index 0 is hardwired to zero and never pending.
REQ-020 SHALL write Wr_data into reg[Rd] on a rising clk when W_en=1 and Rd!=0; writes with Rd=0 have no effect.
REQ-021 SHALL drive Rd_data1/2 combinationally from reg[Rs1]/reg[Rs2], with zero returned for index 0.
REQ-022 SHALL, when BYPASS=1, W_en=1 and Rd==RsN!=0, return Wr_data on Rd_dataN in the same cycle; when BYPASS=0, return the stored value, with the new value visible from the next cycle.
REQ-023 SHALL compute BusyN = pend[RsN] and not (BYPASS and W_en and Rd==RsN); BusyN=0 when RsN=0.
REQ-024 SHALL compute Stall = Iss_en and (Busy1 or Busy2 or (pend[Iss_rd] and not (W_en and Rd==Iss_rd))), a combinational output.
REQ-025 SHALL set pend[Iss_rd] on a rising clk when Iss_en=1, Stall=0 and Iss_rd!=0; a stalled issue changes no state.
REQ-026 SHALL clear pend[Rd] on a rising clk when W_en=1, unless the same edge sets it via REQ-025 (issue wins).
REQ-027 SHALL accept W_en to a non-pending register (plain write, no pending change).
REQ-028 SHALL allow the Rs1==Rs2 case, giving identical data and busy on both ports.
REQ-029 SHALL have zero cycles of read latency and a one-edge write and pending update.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously clear all registers and pending bits, giving Rd_data1=Rd_data2=0, Busy1=Busy2=0 and Stall=0.
REQ-031 SHALL discard a W_en or Iss_en coincident with reset, leaving no state change after release.

Verification
REQ-032 SHALL cover: reset, then W_en=1, Rd=1, Wr_data=A5A5A5A5, then Rs1=1 -> Rd_data1=A5A5A5A5; Rs2=2 -> Rd_data2=0.
REQ-033 SHALL cover: W_en=1, Rd=0, Wr_data=FFFFFFFF, then Rs1=0 -> Rd_data1=0; Iss_en with Iss_rd=0 -> no pending bit set.
REQ-034 SHALL cover, with BYPASS=1: W_en=1, Rd=3, Wr_data=12345678 and Rs1=3 in the same cycle -> Rd_data1=12345678, Busy1=0 in that cycle.
REQ-035 SHALL cover: issue Iss_rd=5, then Rs2=5 -> Busy2=1; Iss_en with Rs1=5 -> Stall=1 and no state change; writeback Rd=5 -> Busy2=0 on the next cycle.
REQ-036 SHALL cover: pend[7]=1, then in one cycle W_en=1, Rd=7 with Iss_en=1, Iss_rd=7 -> Stall=0, reg[7] is updated and pend[7] remains 1.
REQ-037 SHALL cover: rst_n pulsed low mid-sequence with pend[5]=1 and reg[1]!=0 -> all outputs 0 and all pending bits clear immediately, without waiting for a clk edge.
